// File: rtl/swipt_pkg.sv
// Shared SWIPT definitions: program-code encodings and default setpoints,
// used by the mode sequencer and by the Freq, Data and DutyAdjust blocks.
package swipt_pkg;

    typedef enum logic [1:0] {
        PRG_IDLE = 2'b00,
        PRG_FREQ = 2'b01,
        PRG_MEAS = 2'b10,
        PRG_DATA = 2'b11
    } prg_e;

    localparam logic [19:0] START_FREQ_DEF = 20'h9470;
    localparam logic [11:0] START_DUTY_DEF = 12'hC8;
    localparam logic [11:0] DUTY_MAX_DEF   = 12'h1F4;
    localparam logic [11:0] DUTY_MIN_DEF   = 12'h032;

    localparam int CNT_W = 24;

endpackage

// File: rtl/swipt_duty_stepper.sv
// Combinational duty step: moves duty by a tenth of itself (truncated)
// up or down, clamped to [DUTY_MIN, DUTY_MAX].
module swipt_duty_stepper
    import swipt_pkg::*;
#(
    parameter logic [11:0] DUTY_MAX = DUTY_MAX_DEF,
    parameter logic [11:0] DUTY_MIN = DUTY_MIN_DEF
) (
    input  logic [11:0] duty,
    input  logic        step_down,
    output logic [11:0] duty_next
);

    logic [11:0] step;
    logic [12:0] sum;
    logic [12:0] diff;

    // 13-bit arithmetic so an up-step near full scale cannot wrap before the clamp.
    always_comb begin
        step = duty / 12'd10;
        sum  = {1'b0, duty} + {1'b0, step};
        diff = {1'b0, duty} - {1'b0, step};
        duty_next = duty;
        if (step_down) begin
            duty_next = (diff > {1'b0, DUTY_MIN}) ? diff[11:0] : DUTY_MIN;
        end else begin
            duty_next = (sum < {1'b0, DUTY_MAX}) ? sum[11:0] : DUTY_MAX;
        end
    end

endmodule

// File: rtl/swipt_mode_sequencer.sv
// SWIPT operating-mode controller: frequency search, settle/measure window,
// then data-driven duty adjustment, with heartbeat-loss and comms override.
module swipt_mode_sequencer
    import swipt_pkg::*;
#(
    parameter logic [19:0] START_FREQ    = START_FREQ_DEF,
    parameter logic [11:0] START_DUTY    = START_DUTY_DEF,
    parameter logic [11:0] DUTY_MAX      = DUTY_MAX_DEF,
    parameter logic [11:0] DUTY_MIN      = DUTY_MIN_DEF,
    parameter int unsigned SETTLE_CYCLES = 5000000,
    parameter int unsigned MEAS_CYCLES   = 2000000,
    parameter int unsigned FREQ_TIMEOUT  = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        swipt_alive,
    input  logic        comms_override,
    input  logic [19:0] comms_freq,
    input  logic [11:0] comms_duty,
    input  logic        freq_alg_done,
    input  logic [19:0] new_freq,
    input  logic [19:0] best_freq,
    input  logic        duty_step_valid,
    input  logic        duty_step_down,
    input  logic        data_mean_req,
    output logic [1:0]  program_code,
    output logic [19:0] freq,
    output logic [11:0] duty,
    output logic        measure,
    output logic        freq_fallback
);

    localparam logic [CNT_W-1:0] MEAS_LOAD = CNT_W'(SETTLE_CYCLES + MEAS_CYCLES);
    localparam logic [CNT_W-1:0] MEAS_THR  = CNT_W'(MEAS_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(FREQ_TIMEOUT - 1);
    localparam logic             MEAS_AT_LOAD = (MEAS_LOAD != '0) && (MEAS_LOAD <= MEAS_THR);

    prg_e             state_q, state_d;
    logic [19:0]      freq_q, freq_d;
    logic [11:0]      duty_q, duty_d;
    logic             measure_q, measure_d;
    logic             fallback_q, fallback_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      duty_stepped;

    swipt_duty_stepper #(
        .DUTY_MAX (DUTY_MAX),
        .DUTY_MIN (DUTY_MIN)
    ) u_stepper (
        .duty      (duty_q),
        .step_down (duty_step_down),
        .duty_next (duty_stepped)
    );

    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        duty_d     = duty_q;
        measure_d  = 1'b0;
        fallback_d = fallback_q;
        cnt_d      = cnt_q;

        if (comms_override) begin
            state_d = PRG_IDLE;
            freq_d  = comms_freq;
            duty_d  = comms_duty;
            cnt_d   = '0;
        end else begin
            case (state_q)
                PRG_IDLE: begin
                    state_d = PRG_FREQ;
                    cnt_d   = '0;
                end
                PRG_FREQ: begin
                    // A lock arriving on the timeout cycle still takes the found frequency.
                    if (freq_alg_done) begin
                        freq_d    = best_freq;
                        cnt_d     = MEAS_LOAD;
                        measure_d = MEAS_AT_LOAD;
                        state_d   = PRG_MEAS;
                    end else if (cnt_q >= TMO_LAST) begin
                        freq_d     = START_FREQ;
                        fallback_d = 1'b1;
                        cnt_d      = MEAS_LOAD;
                        measure_d  = MEAS_AT_LOAD;
                        state_d    = PRG_MEAS;
                    end else begin
                        freq_d = new_freq;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                PRG_MEAS: begin
                    // measure tracks the registered count: high only for counts 1..MEAS_CYCLES.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = PRG_DATA;
                    end else begin
                        cnt_d     = cnt_q - CNT_W'(1);
                        measure_d = (cnt_d <= MEAS_THR);
                    end
                end
                PRG_DATA: begin
                    measure_d = data_mean_req;
                    if (duty_step_valid) begin
                        duty_d = duty_stepped;
                    end
                end
                default: begin
                    state_d = PRG_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !swipt_alive) begin
            state_q    <= PRG_IDLE;
            freq_q     <= START_FREQ;
            duty_q     <= START_DUTY;
            measure_q  <= 1'b0;
            fallback_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            freq_q     <= freq_d;
            duty_q     <= duty_d;
            measure_q  <= measure_d;
            fallback_q <= fallback_d;
            cnt_q      <= cnt_d;
        end
    end

    assign program_code  = state_q;
    assign freq          = freq_q;
    assign duty          = duty_q;
    assign measure       = measure_q;
    assign freq_fallback = fallback_q;

endmodule
